// File: rtl/mole_spawner.sv
// mole_spawner: decides when and which mole pops up.
// A slow tick strobe paces spawn attempts, a 16-bit Galois LFSR picks the
// starting candidate, and a linear probe walks to the next hiding mole.
// The one-hot go request is held until the mole leaves its hiding state
// or the acknowledge timer expires.
module mole_spawner #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          MAX_ACTIVE  = 3,
    parameter int          ACK_TIMEOUT = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        tick,
    input  logic [7:0]  interval,
    input  logic [7:0]  hiding,
    output logic [7:0]  control,
    output logic        busy,
    output logic [15:0] spawn_count,
    output logic        ack_error
);

    localparam int                 TIMER_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]         ACTIVE_LIMIT = 4'(MAX_ACTIVE);
    localparam logic [15:0]        LFSR_MASK    = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PICK  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t               r_state;
    logic [15:0]          r_lfsr;
    logic [7:0]           r_tickCnt;
    logic [2:0]           r_cand;
    logic [2:0]           r_probe;
    logic [TIMER_W-1:0]   r_timer;
    logic [7:0]           r_control;
    logic                 r_busy;
    logic [15:0]          r_spawnCount;
    logic                 r_ackError;

    logic [3:0]           w_active;
    logic [7:0]           w_tickTarget;
    logic                 w_candFree;
    logic                 w_roomFree;
    logic [7:0]           w_candOneHot;

    assign control     = r_control;
    assign busy        = r_busy;
    assign spawn_count = r_spawnCount;
    assign ack_error   = r_ackError;

    // Number of moles currently out of hiding (zeros in the hiding vector).
    always_comb begin
        w_active = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_active = w_active + {3'd0, ~hiding[i]};
        end
    end

    // An interval of 0 behaves like 1, so the match target is interval-1 clamped at 0.
    assign w_tickTarget = (interval == 8'd0) ? 8'd0 : (interval - 8'd1);
    assign w_candFree   = hiding[r_cand];
    assign w_roomFree   = (w_active < ACTIVE_LIMIT);
    assign w_candOneHot = 8'd1 << r_cand;

    // Galois LFSR free-runs while the game is enabled; the nonzero seed keeps it off zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (enable) begin
            if (r_lfsr[0]) begin
                r_lfsr <= (r_lfsr >> 1) ^ LFSR_MASK;
            end else begin
                r_lfsr <= r_lfsr >> 1;
            end
        end
    end

    // Spawn FSM: pace with ticks, probe for a free mole, hold the request until acknowledged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tickCnt    <= 8'd0;
            r_cand       <= 3'd0;
            r_probe      <= 3'd0;
            r_timer      <= '0;
            r_control    <= 8'd0;
            r_busy       <= 1'b0;
            r_spawnCount <= 16'd0;
            r_ackError   <= 1'b0;
        end else if (!enable) begin
            r_state   <= IDLE;
            r_tickCnt <= 8'd0;
            r_probe   <= 3'd0;
            r_timer   <= '0;
            r_control <= 8'd0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_tickCnt <= 8'd0;
                    r_probe   <= 3'd0;
                    r_timer   <= '0;
                    r_control <= 8'd0;
                    r_busy    <= 1'b0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (tick) begin
                        if (r_tickCnt == w_tickTarget) begin
                            r_tickCnt <= 8'd0;
                            r_cand    <= r_lfsr[2:0];
                            r_probe   <= 3'd0;
                            r_busy    <= 1'b1;
                            r_state   <= PICK;
                        end else begin
                            r_tickCnt <= r_tickCnt + 8'd1;
                        end
                    end
                end
                PICK: begin
                    if (w_candFree && w_roomFree) begin
                        r_control <= w_candOneHot;
                        r_timer   <= '0;
                        r_state   <= ISSUE;
                    end else if (!w_roomFree) begin
                        r_busy  <= 1'b0;
                        r_state <= WAIT;
                    end else begin
                        r_cand <= r_cand + 3'd1;
                        if (r_probe == 3'd7) begin
                            r_busy  <= 1'b0;
                            r_state <= WAIT;
                        end else begin
                            r_probe <= r_probe + 3'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (!hiding[r_cand]) begin
                        r_control <= 8'd0;
                        r_busy    <= 1'b0;
                        r_state   <= WAIT;
                        if (r_spawnCount != 16'hFFFF) begin
                            r_spawnCount <= r_spawnCount + 16'd1;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_control  <= 8'd0;
                        r_busy     <= 1'b0;
                        r_ackError <= 1'b1;
                        r_state    <= WAIT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_control <= 8'd0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
